// File: rtl/vga_layer_mixer.sv
// ---------------------------------------------------------------------------
// vga_layer_mixer
//
// Purpose:
//   Merges NUM_LAYERS RGB layers (background, dino, dangers, HUD, ...) into a
//   single VGA pixel stream with a fixed two-cycle latency. Two mixing modes:
//     mode = 0 : AND mode, the bitwise AND of every effective layer pixel
//                (drop-in replacement for the old three-layer compositor).
//     mode = 1 : priority / colour-key mode, the lowest-index layer whose
//                pixel differs from KEY_COLOR wins; KEY_COLOR if none does.
//   Optionally tracks collisions between layer 0 (the dino) and any other
//   opaque layer: a sticky flag plus a per-frame hit count.
//
// Optional feature macro:
//   MIXER_COLLISION_EN - when defined, builds the collision flag, the hit
//   accumulator and the frame_hits register. When undefined, collision and
//   frame_hits are constant 0 and collision_clr has no effect. Mixing and
//   latency are identical in both builds.
//
// Ports:
//   clk           in   pixel clock, all logic on the rising edge
//   rst           in   asynchronous active-low reset
//   mode          in   0 = AND mode, 1 = priority/colour-key mode
//   valid_in      in   active-video qualifier
//   h_cnt         in   horizontal pixel counter (10 bits)
//   v_cnt         in   vertical line counter (10 bits)
//   layer_rgb     in   packed {R,G,B} per layer, layer i at slice i
//   layer_en      in   per-layer enable, disabled layer reads as KEY_COLOR
//   collision_clr in   clears the sticky collision flag
//   valid_out     out  valid_in delayed by two cycles
//   rgb_out       out  mixed pixel {R,G,B}, 0 outside active video
//   collision     out  sticky dino-overlap flag
//   frame_hits    out  overlap pixel count of the last completed frame
//
// hsync/vsync are not handled here and must be delayed by two cycles
// outside this block so they stay aligned with rgb_out.
// ---------------------------------------------------------------------------
module vga_layer_mixer #(
  parameter int                         NUM_LAYERS = 3,
  parameter int                         COLOR_W    = 4,
  parameter logic [3*COLOR_W-1:0]       KEY_COLOR  = 12'hFFF,
  parameter int                         CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mode,
  input  logic                            valid_in,
  input  logic [9:0]                      h_cnt,
  input  logic [9:0]                      v_cnt,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]           layer_en,
  input  logic                            collision_clr,
  output logic                            valid_out,
  output logic [3*COLOR_W-1:0]            rgb_out,
  output logic                            collision,
  output logic [CNT_W-1:0]                frame_hits
);

  localparam int PW = 3 * COLOR_W;

  // -------------------------------------------------------------------------
  // Stage 1 inputs: effective pixel per layer and its opacity
  // -------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0][PW-1:0] w_eff_pix;
  logic [NUM_LAYERS-1:0]         w_eff_opq;

  // A disabled layer is replaced by the key colour, so it is transparent in
  // priority mode and all-ones (neutral) in AND mode when KEY_COLOR is white.
  always_comb begin
    w_eff_pix = '0;
    w_eff_opq = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_eff_pix[i] = layer_en[i] ? layer_rgb[i*PW +: PW] : KEY_COLOR;
      w_eff_opq[i] = (w_eff_pix[i] != KEY_COLOR);
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 registers
  // -------------------------------------------------------------------------
  logic                          r_s1_valid;
  logic                          r_s1_mode;
  logic [NUM_LAYERS-1:0][PW-1:0] r_s1_pix;
  logic [NUM_LAYERS-1:0]         r_s1_opq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_opq   <= '0;
    end else begin
      r_s1_valid <= valid_in;
      r_s1_mode  <= mode;
      r_s1_pix   <= w_eff_pix;
      r_s1_opq   <= w_eff_opq;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2 mixing
  // -------------------------------------------------------------------------
  logic [PW-1:0] w_and_pix;
  logic [PW-1:0] w_pri_pix;
  logic [PW-1:0] w_mix_pix;

  // Priority search walks from the highest index down so the last opaque
  // layer written is the lowest index, which has the highest priority.
  always_comb begin
    w_and_pix = '1;
    w_pri_pix = KEY_COLOR;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_and_pix = w_and_pix & r_s1_pix[i];
    end
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_s1_opq[i]) begin
        w_pri_pix = r_s1_pix[i];
      end
    end
    w_mix_pix = r_s1_mode ? w_pri_pix : w_and_pix;
  end

  // -------------------------------------------------------------------------
  // Stage 2 output registers; blanking forces the colour to black
  // -------------------------------------------------------------------------
  logic          r_valid_out;
  logic [PW-1:0] r_rgb_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_out <= 1'b0;
      r_rgb_out   <= '0;
    end else begin
      r_valid_out <= r_s1_valid;
      r_rgb_out   <= r_s1_valid ? w_mix_pix : '0;
    end
  end

  assign valid_out = r_valid_out;
  assign rgb_out   = r_rgb_out;

`ifdef MIXER_COLLISION_EN
  // -------------------------------------------------------------------------
  // Collision detection
  // -------------------------------------------------------------------------
  logic             r_s1_fs;
  logic             w_hit;
  logic             w_acc_full;
  logic [CNT_W-1:0] w_hit_ext;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_frame_hits;
  logic             r_collision;

  // Frame start marks the first active pixel of a frame; it travels with the
  // pixel so the frame boundary lines up with the hit it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_fs <= 1'b0;
    end else begin
      r_s1_fs <= valid_in && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

  // A hit is the dino being opaque on a pixel where any other layer is too,
  // regardless of which mixing mode is selected.
  assign w_hit      = r_s1_valid & r_s1_opq[0] & (|r_s1_opq[NUM_LAYERS-1:1]);
  assign w_acc_full = &r_acc;
  assign w_hit_ext  = {{(CNT_W-1){1'b0}}, w_hit};

  // The frame-start pixel closes the previous frame and is itself the first
  // pixel counted in the new one. The count saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc        <= '0;
      r_frame_hits <= '0;
    end else if (r_s1_fs) begin
      r_frame_hits <= r_acc;
      r_acc        <= w_hit_ext;
    end else if (w_hit && !w_acc_full) begin
      r_acc <= r_acc + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky flag: a hit in the same cycle as a clear keeps the flag set so
  // an overlap is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_collision <= 1'b0;
    end else if (w_hit) begin
      r_collision <= 1'b1;
    end else if (collision_clr) begin
      r_collision <= 1'b0;
    end
  end

  assign collision  = r_collision;
  assign frame_hits = r_frame_hits;
`else
  // Collision logic not built; the inputs that only feed it are folded into
  // an intentionally unused signal.
  logic w_unused;

  assign w_unused   = ^{collision_clr, h_cnt, v_cnt};
  assign collision  = 1'b0;
  assign frame_hits = '0;
`endif

endmodule

// File: tb/tb_vga_layer_mixer.sv
// ---------------------------------------------------------------------------
// tb_vga_layer_mixer
//
// Scoreboard bench for vga_layer_mixer. The driver applies one pixel per
// clock and, one cycle later (once the collision_clr that pairs with that
// pixel is known), pushes the reference result into a queue tagged with the
// cycle at which the DUT must show it. A separate monitor pops and compares.
// Uses a three-bit hit counter so saturation is reached quickly.
// Honours MIXER_COLLISION_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_vga_layer_mixer;

  localparam int          NL   = 3;
  localparam int          CW   = 4;
  localparam int          PW   = 3 * CW;
  localparam int          CNTW = 3;
  localparam logic [11:0] KEY  = 12'hFFF;
  localparam int          HMAX = (1 << CNTW) - 1;

  logic               clk;
  logic               rst;
  logic               mode;
  logic               valid_in;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic [NL*PW-1:0]   layer_rgb;
  logic [NL-1:0]      layer_en;
  logic               collision_clr;
  logic               valid_out;
  logic [PW-1:0]      rgb_out;
  logic               collision;
  logic [CNTW-1:0]    frame_hits;

  vga_layer_mixer #(
    .NUM_LAYERS (NL),
    .COLOR_W    (CW),
    .KEY_COLOR  (KEY),
    .CNT_W      (CNTW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .valid_in      (valid_in),
    .h_cnt         (h_cnt),
    .v_cnt         (v_cnt),
    .layer_rgb     (layer_rgb),
    .layer_en      (layer_en),
    .collision_clr (collision_clr),
    .valid_out     (valid_out),
    .rgb_out       (rgb_out),
    .collision     (collision),
    .frame_hits    (frame_hits)
  );

  typedef struct {
    int              due;
    logic            valid;
    logic [PW-1:0]   rgb;
    logic            coll;
    logic [CNTW-1:0] hits;
  } exp_t;

  exp_t        scb[$];
  int          cyc = 0;
  int          nVec = 0;
  int          nErr = 0;

  // previous applied pixel, waiting for its paired collision_clr
  bit          hasPrev = 0;
  logic        pMode;
  logic        pValid;
  int          pH;
  int          pV;
  logic [11:0] pLay[NL];
  logic [NL-1:0] pEn;

  // reference model state
  int          mAcc  = 0;
  int          mHits = 0;
  bit          mColl = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference result for the previous pixel, written from the mixing rules:
  // AND of effective pixels, or first non-key layer in index order.
  task automatic modelStep(input logic clr);
    logic [11:0] eff[NL];
    bit          opq[NL];
    bit          hit;
    bit          fs;
    bit          found;
    exp_t        e;
    logic [11:0] andPix;
    logic [11:0] priPix;
    int          others;

    andPix = 12'hFFF;
    priPix = KEY;
    found  = 0;
    others = 0;
    for (int i = 0; i < NL; i++) begin
      eff[i] = pEn[i] ? pLay[i] : KEY;
      opq[i] = (eff[i] != KEY);
      andPix = andPix & eff[i];
      if (opq[i] && !found) begin
        priPix = eff[i];
        found  = 1;
      end
      if (i > 0 && opq[i]) others++;
    end
    hit = pValid && opq[0] && (others > 0);
    fs  = pValid && (pH == 0) && (pV == 0);

`ifdef MIXER_COLLISION_EN
    if (fs) begin
      mHits = mAcc;
      mAcc  = hit ? 1 : 0;
    end else if (hit) begin
      mAcc = (mAcc + 1 > HMAX) ? HMAX : mAcc + 1;
    end
    if (hit) mColl = 1;
    else if (clr) mColl = 0;
`else
    mHits = 0;
    mColl = 0;
`endif

    e.due   = cyc + 1;
    e.valid = pValid;
    e.rgb   = !pValid ? 12'h000 : (pMode ? priPix : andPix);
    e.coll  = mColl;
    e.hits  = CNTW'(mHits);
    scb.push_back(e);
  endtask

  task automatic applyStimulus(input logic m, input logic [11:0] l0, input logic [11:0] l1,
                               input logic [11:0] l2, input logic [NL-1:0] en, input logic v,
                               input int h, input int vv, input logic clr);
    @(posedge clk);
    #1;
    if (hasPrev) modelStep(clr);
    mode          = m;
    layer_rgb     = {l2, l1, l0};
    layer_en      = en;
    valid_in      = v;
    h_cnt         = 10'(h);
    v_cnt         = 10'(vv);
    collision_clr = clr;
    pMode   = m;
    pValid  = v;
    pH      = h;
    pV      = vv;
    pLay[0] = l0;
    pLay[1] = l1;
    pLay[2] = l2;
    pEn     = en;
    hasPrev = 1;
  endtask

  // Monitor: compare the DUT against whatever result is due this cycle.
  always @(negedge clk) begin
    if (rst) begin
      while (scb.size() > 0 && scb[0].due < cyc) begin
        void'(scb.pop_front());
        checkOutput("missed_item", 32'd1, 32'd0);
      end
      if (scb.size() > 0 && scb[0].due == cyc) begin
        exp_t e;
        e = scb.pop_front();
        checkOutput("valid_out", 32'(valid_out), 32'(e.valid));
        checkOutput("rgb_out", 32'(rgb_out), 32'(e.rgb));
        checkOutput("collision", 32'(collision), 32'(e.coll));
        checkOutput("frame_hits", 32'(frame_hits), 32'(e.hits));
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    checkOutput({tag, "_rgb_out"}, 32'(rgb_out), 32'd0);
    checkOutput({tag, "_collision"}, 32'(collision), 32'd0);
    checkOutput({tag, "_frame_hits"}, 32'(frame_hits), 32'd0);
  endtask

  function automatic logic [11:0] randPix();
    logic [11:0] p;
    p = 12'($urandom);
    return ($urandom_range(0, 2) == 0) ? KEY : p;
  endfunction

  initial begin
    rst           = 1'b0;
    mode          = 1'b0;
    valid_in      = 1'b0;
    h_cnt         = '0;
    v_cnt         = '0;
    layer_rgb     = '0;
    layer_en      = '1;
    collision_clr = 1'b0;
    #2;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // AND mode: FFF & F0F & 0FF = 00F
    applyStimulus(0, 12'hFFF, 12'hF0F, 12'h0FF, 3'b111, 1, 10, 10, 0);
    // priority mode, layer enables, all transparent
    applyStimulus(1, 12'hFFF, 12'h123, 12'h456, 3'b111, 1, 11, 10, 0);
    applyStimulus(1, 12'hFFF, 12'h123, 12'h456, 3'b101, 1, 12, 10, 0);
    applyStimulus(1, 12'hFFF, 12'hFFF, 12'hFFF, 3'b111, 1, 13, 10, 0);
    applyStimulus(1, 12'h321, 12'h123, 12'h456, 3'b000, 1, 14, 10, 0);
    // blanking with nonzero layers, then back to active on both edges
    applyStimulus(0, 12'h0F0, 12'h0F0, 12'h0F0, 3'b111, 0, 15, 10, 0);
    applyStimulus(0, 12'h0F0, 12'h0F0, 12'h0F0, 3'b111, 1, 16, 10, 0);
    applyStimulus(0, 12'h0F0, 12'h0F0, 12'h0F0, 3'b111, 0, 17, 10, 0);

    // frame N: start pixel, five dino/danger overlaps, then next frame start
    applyStimulus(1, KEY, KEY, KEY, 3'b111, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      applyStimulus(1, 12'h0A0, KEY, 12'h00B, 3'b111, 1, i, 0, 0);
    applyStimulus(1, KEY, 12'h111, KEY, 3'b111, 1, 6, 0, 0);
    applyStimulus(1, KEY, KEY, KEY, 3'b111, 1, 0, 0, 0);
    // clear with no hit on the paired pixel, then clear together with a hit
    applyStimulus(1, KEY, KEY, KEY, 3'b111, 1, 1, 0, 1);
    applyStimulus(0, 12'h0A0, 12'h222, KEY, 3'b111, 1, 2, 0, 0);
    applyStimulus(0, KEY, KEY, KEY, 3'b111, 1, 3, 0, 1);
    applyStimulus(0, KEY, KEY, KEY, 3'b111, 1, 4, 0, 0);

    // ten overlaps in one frame saturate a three-bit counter at 7
    for (int i = 5; i < 15; i++)
      applyStimulus(0, 12'h0C0, 12'h333, 12'h444, 3'b111, 1, i, 0, 0);
    applyStimulus(0, KEY, KEY, KEY, 3'b111, 1, 0, 0, 1);
    applyStimulus(0, 12'h0C0, 12'h333, KEY, 3'b111, 1, 1, 0, 0);
    applyStimulus(0, 12'h5A5, 12'h333, KEY, 3'b111, 1, 2, 0, 0);

    // asynchronous reset in the middle of a cycle, mid-frame
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    scb.delete();
    hasPrev = 0;
    mAcc    = 0;
    mHits   = 0;
    mColl   = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // randomized traffic with occasional frame starts and clears
    for (int n = 0; n < 2000; n++) begin
      int          h;
      int          vv;
      int          sel;
      logic [2:0]  en;
      sel = $urandom_range(0, 29);
      if (sel == 0) begin
        h = 0; vv = 0;
      end else if (sel == 1) begin
        h = 0; vv = $urandom_range(1, 479);
      end else if (sel == 2) begin
        h = $urandom_range(1, 639); vv = 0;
      end else begin
        h = $urandom_range(1, 639); vv = $urandom_range(0, 479);
      end
      en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      applyStimulus(1'($urandom), randPix(), randPix(), randPix(), en,
                    ($urandom_range(0, 7) != 0), h, vv, ($urandom_range(0, 7) == 0));
    end

    // drain the pipeline
    repeat (3) applyStimulus(0, KEY, KEY, KEY, 3'b111, 0, 1, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(scb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
